// File: rtl/cv32e40s_alert_sequencer.sv
// Alert sequencer: leaky minor-alert counter with escalation, and a four-phase
// req/ack handshake that carries a severity code toward the SoC alert receiver.
module cv32e40s_alert_sequencer #(
  parameter int unsigned MINOR_THRESHOLD = 4,
  parameter int unsigned LEAK_PERIOD     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alert_minor_i,
  input  logic       alert_major_i,
  input  logic       alert_ack_i,
  output logic       alert_req_o,
  output logic [1:0] alert_severity_o,
  output logic       alert_fatal_o,
  output logic [3:0] minor_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_LOW
  } state_e;

  localparam logic [3:0]  THRESH   = 4'(MINOR_THRESHOLD);
  localparam logic [15:0] LEAK_MAX = 16'(LEAK_PERIOD - 1);

  localparam logic [1:0] SEV_IDLE  = 2'b00;
  localparam logic [1:0] SEV_MINOR = 2'b01;
  localparam logic [1:0] SEV_MAJOR = 2'b10;

  state_e      state_q;
  logic [3:0]  count_q;
  logic [15:0] leak_q;
  logic        pend_major_q;
  logic        pend_minor_q;
  logic        fatal_q;
  logic        req_q;
  logic [1:0]  sev_q;

  logic [3:0]  count_inc;
  logic        escalate;
  logic        new_major;
  logic        new_minor;

  // An escalating minor is delivered only as a major, never as a minor too.
  assign count_inc = count_q + 4'd1;
  assign escalate  = alert_minor_i && (count_inc == THRESH);
  assign new_major = alert_major_i || escalate;
  assign new_minor = alert_minor_i && !escalate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
      leak_q  <= 16'd0;
    end else if (alert_minor_i) begin
      count_q <= escalate ? 4'd0 : count_inc;
      leak_q  <= 16'd0;
    end else if (count_q != 4'd0) begin
      if (leak_q == LEAK_MAX) begin
        leak_q  <= 16'd0;
        count_q <= count_q - 4'd1;
      end else begin
        leak_q <= leak_q + 16'd1;
      end
    end else begin
      leak_q <= 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fatal_q <= 1'b0;
    end else if (new_major) begin
      fatal_q <= 1'b1;
    end
  end

  // A major launch absorbs any pending minor; alerts arriving mid-handshake
  // are parked in the pending flags until the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      sev_q        <= SEV_IDLE;
      pend_major_q <= 1'b0;
      pend_minor_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_major_q || new_major) begin
            state_q      <= REQ;
            req_q        <= 1'b1;
            sev_q        <= SEV_MAJOR;
            pend_major_q <= 1'b0;
            pend_minor_q <= 1'b0;
          end else if (pend_minor_q || new_minor) begin
            state_q      <= REQ;
            req_q        <= 1'b1;
            sev_q        <= SEV_MINOR;
            pend_minor_q <= 1'b0;
          end
        end
        REQ: begin
          pend_major_q <= pend_major_q || new_major;
          pend_minor_q <= pend_minor_q || new_minor;
          if (alert_ack_i) begin
            state_q <= WAIT_LOW;
            req_q   <= 1'b0;
          end
        end
        WAIT_LOW: begin
          pend_major_q <= pend_major_q || new_major;
          pend_minor_q <= pend_minor_q || new_minor;
          if (!alert_ack_i) begin
            state_q <= IDLE;
            sev_q   <= SEV_IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          sev_q   <= SEV_IDLE;
        end
      endcase
    end
  end

  assign alert_req_o      = req_q;
  assign alert_severity_o = sev_q;
  assign alert_fatal_o    = fatal_q;
  assign minor_count_o    = count_q;

endmodule
